// File: rtl/compare_pkg.sv
// Shared types for the serial magnitude comparator: controller state encoding
// and the one-hot {gt,eq,lt} result vector.
package compare_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } cmp_state_t;

   localparam logic [2:0] CMP_GT   = 3'b100;
   localparam logic [2:0] CMP_EQ   = 3'b010;
   localparam logic [2:0] CMP_LT   = 3'b001;
   localparam logic [2:0] CMP_NONE = 3'b000;

endpackage

// File: rtl/cmp_bit_slice.sv
// One-bit magnitude compare slice; the controller walks it MSB first.
module cmp_bit_slice (
   input  logic a,
   input  logic b,
   output logic gt,
   output logic eq,
   output logic lt
);

   always_comb begin
      if (a && !b) begin
         gt = 1'b1;
         eq = 1'b0;
         lt = 1'b0;
      end else if (!a && b) begin
         gt = 1'b0;
         eq = 1'b0;
         lt = 1'b1;
      end else begin
         gt = 1'b0;
         eq = 1'b1;
         lt = 1'b0;
      end
   end

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial unsigned comparator: scans WIDTH bits MSB first through one
// cmp_bit_slice and returns a registered one-hot gt/eq/lt with the scan length.
//
// state | meaning
// IDLE  | waiting for operands, start_ready high
// SCAN  | one slice evaluation per cycle, index counting down to 0
// DONE  | result held, res_valid high until res_ready
module serial_compare_ctrl
   import compare_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int EARLY_EXIT = 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       start_valid,
   output logic                       start_ready,
   input  logic [WIDTH-1:0]           a_in,
   input  logic [WIDTH-1:0]           b_in,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic                       gt,
   output logic                       eq,
   output logic                       lt,
   output logic                       busy,
   output logic [$clog2(WIDTH+1)-1:0] cycles
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   cmp_state_t       state_q;
   cmp_state_t       state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] cycles_q;
   logic [2:0]       res_q;
   logic             decided_q;

   logic             s_gt;
   logic             s_eq;
   logic             s_lt;
   logic             accept;
   logic             diff;
   logic             last;

   // Operands shift left each SCAN cycle, so the slice always sees the MSB.
   cmp_bit_slice u_slice (
      .a  (a_q[WIDTH-1]),
      .b  (b_q[WIDTH-1]),
      .gt (s_gt),
      .eq (s_eq),
      .lt (s_lt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      accept    = 1'b0;
      diff      = !s_eq;
      last      = (idx_q == '0);
      case (state_q)
         IDLE: begin
            if (start_valid) begin
               accept    = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (last || ((EARLY_EXIT != 0) && diff)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_q       <= '0;
         b_q       <= '0;
         idx_q     <= '0;
         cycles_q  <= '0;
         res_q     <= CMP_NONE;
         decided_q <= 1'b0;
      end else if (accept) begin
         a_q       <= a_in;
         b_q       <= b_in;
         idx_q     <= IDX_W'(WIDTH - 1);
         cycles_q  <= '0;
         res_q     <= CMP_NONE;
         decided_q <= 1'b0;
      end else if (state_q == SCAN) begin
         a_q      <= a_q << 1;
         b_q      <= b_q << 1;
         cycles_q <= cycles_q + CNT_W'(1);
         if (!last) begin
            idx_q <= idx_q - IDX_W'(1);
         end
         // First difference wins; later bits in a full scan never overwrite it.
         if (!decided_q && diff) begin
            res_q     <= {s_gt, 1'b0, s_lt};
            decided_q <= 1'b1;
         end else if (!decided_q && last) begin
            res_q <= CMP_EQ;
         end
      end
   end

   assign start_ready = (state_q == IDLE);
   assign busy        = (state_q != IDLE);
   assign res_valid   = (state_q == DONE);
   assign gt          = res_q[2];
   assign eq          = res_q[1];
   assign lt          = res_q[0];
   assign cycles      = cycles_q;

endmodule
